// File: rtl/mii_loopback_phy.sv
// mii_loopback_phy: simulation MII PHY that captures MAC TX frames and replays them on RX
module mii_loopback_phy #(
  parameter int HALF = 2,
  parameter int DEPTH = 4096,
  parameter int LQ_DEPTH = 4,
  parameter int TURN = 16,
  parameter int IFG = 24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        loop_en,
  output logic        mtx_clk,
  input  logic [3:0]  mtxd,
  input  logic        mtxen,
  input  logic        mtxerr,
  output logic        mrx_clk,
  output logic [3:0]  mrxd,
  output logic        mrxdv,
  output logic        mrxerr,
  output logic        mcoll,
  output logic        mcrs,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(LQ_DEPTH);
  localparam int DW = HALF > 1 ? $clog2(HALF) : 1;
  localparam logic T_IDLE = 1'b0;
  localparam logic T_CAP = 1'b1;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_SEND = 2'd2;
  localparam logic [1:0] R_IFG = 2'd3;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic mtx_clk_q, mtx_clk_d;
  logic t_state_q, t_state_d, tx_drop_q, tx_drop_d, skip_q, skip_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, fs_ptr_q, fs_ptr_d, tx_len_q, tx_len_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, rx_len_q, rx_len_d;
  logic [LW:0] lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
  logic [1:0] r_state_q, r_state_d;
  logic [15:0] r_cnt_q, r_cnt_d, frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [3:0] mrxd_q, mrxd_d;
  logic mrxdv_q, mrxdv_d, mrxerr_q, mrxerr_d;
  logic [4:0] mem [DEPTH];
  logic [PW-1:0] lq_mem [LQ_DEPTH];
  logic wrap, fall, fifo_full, lq_full, lq_empty, mem_we, lq_we;

  // MII clock divider, fall-tick strobe and buffer status
  always_comb begin
    wrap = div_cnt_q == DW'(HALF - 1);
    fall = wrap & mtx_clk_q;
    div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
    mtx_clk_d = mtx_clk_q ^ wrap;
    fifo_full = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    lq_full = (lq_wr_q ^ lq_rd_q) == {1'b1, {LW{1'b0}}};
    lq_empty = lq_wr_q == lq_rd_q;
  end

  // TX capture: write nibbles, rewind on overflow, commit length or count a drop
  always_comb begin
    t_state_d = t_state_q;
    tx_drop_d = tx_drop_q;
    skip_d = skip_q;
    wr_ptr_d = wr_ptr_q;
    fs_ptr_d = fs_ptr_q;
    tx_len_d = tx_len_q;
    lq_wr_d = lq_wr_q;
    drop_cnt_d = drop_cnt_q;
    mem_we = 1'b0;
    lq_we = 1'b0;
    if (fall) begin
      if (t_state_q == T_IDLE) begin
        skip_d = mtxen & (skip_q | ~loop_en);
        if (mtxen && loop_en && !skip_q) begin
          t_state_d = T_CAP;
          fs_ptr_d = wr_ptr_q;
          tx_drop_d = lq_full | fifo_full;
          mem_we = ~(lq_full | fifo_full);
          wr_ptr_d = mem_we ? wr_ptr_q + PW'(1) : wr_ptr_q;
          tx_len_d = mem_we ? PW'(1) : '0;
        end
      end else if (mtxen) begin
        if (!tx_drop_q) begin
          tx_drop_d = fifo_full;
          mem_we = ~fifo_full;
          wr_ptr_d = fifo_full ? fs_ptr_q : wr_ptr_q + PW'(1);
          tx_len_d = fifo_full ? tx_len_q : tx_len_q + PW'(1);
        end
      end else begin
        t_state_d = T_IDLE;
        lq_we = ~tx_drop_q;
        lq_wr_d = tx_drop_q ? lq_wr_q : lq_wr_q + (LW+1)'(1);
        drop_cnt_d = tx_drop_q ? drop_cnt_q + 16'd1 : drop_cnt_q;
      end
    end
  end

  // RX replay: pop a length, wait the turnaround, stream the frame, then hold off for IFG
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d = r_cnt_q;
    rx_len_d = rx_len_q;
    rd_ptr_d = rd_ptr_q;
    lq_rd_d = lq_rd_q;
    frame_cnt_d = frame_cnt_q;
    mrxd_d = mrxd_q;
    mrxdv_d = mrxdv_q;
    mrxerr_d = mrxerr_q;
    case (r_state_q)
      R_IDLE: if (!lq_empty) begin
        r_state_d = R_WAIT;
        rx_len_d = lq_mem[lq_rd_q[LW-1:0]];
        lq_rd_d = lq_rd_q + (LW+1)'(1);
        r_cnt_d = 16'(TURN);
      end
      R_WAIT: if (fall) begin
        r_state_d = r_cnt_q <= 16'd1 ? R_SEND : R_WAIT;
        r_cnt_d = r_cnt_q - 16'd1;
      end
      R_SEND: if (fall) begin
        mrxdv_d = rx_len_q != '0;
        {mrxerr_d, mrxd_d} = rx_len_q != '0 ? mem[rd_ptr_q[AW-1:0]] : 5'd0;
        rd_ptr_d = rx_len_q != '0 ? rd_ptr_q + PW'(1) : rd_ptr_q;
        rx_len_d = rx_len_q != '0 ? rx_len_q - PW'(1) : rx_len_q;
        frame_cnt_d = rx_len_q != '0 ? frame_cnt_q : frame_cnt_q + 16'd1;
        r_state_d = rx_len_q != '0 ? R_SEND : R_IFG;
        r_cnt_d = 16'(IFG);
      end
      default: if (fall) begin
        r_state_d = r_cnt_q <= 16'd1 ? R_IDLE : R_IFG;
        r_cnt_d = r_cnt_q - 16'd1;
      end
    endcase
  end

  // State registers; reset discards any partial frame and queued data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt_q <= '0;
      mtx_clk_q <= 1'b0;
      t_state_q <= T_IDLE;
      tx_drop_q <= 1'b0;
      skip_q <= 1'b0;
      wr_ptr_q <= '0;
      fs_ptr_q <= '0;
      tx_len_q <= '0;
      rd_ptr_q <= '0;
      rx_len_q <= '0;
      lq_wr_q <= '0;
      lq_rd_q <= '0;
      r_state_q <= R_IDLE;
      r_cnt_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q <= '0;
      mrxd_q <= '0;
      mrxdv_q <= 1'b0;
      mrxerr_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mtx_clk_q <= mtx_clk_d;
      t_state_q <= t_state_d;
      tx_drop_q <= tx_drop_d;
      skip_q <= skip_d;
      wr_ptr_q <= wr_ptr_d;
      fs_ptr_q <= fs_ptr_d;
      tx_len_q <= tx_len_d;
      rd_ptr_q <= rd_ptr_d;
      rx_len_q <= rx_len_d;
      lq_wr_q <= lq_wr_d;
      lq_rd_q <= lq_rd_d;
      r_state_q <= r_state_d;
      r_cnt_q <= r_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      mrxd_q <= mrxd_d;
      mrxdv_q <= mrxdv_d;
      mrxerr_q <= mrxerr_d;
    end
  end

  // Nibble FIFO storage: {err, data}
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {mtxerr, mtxd};
  end

  // Committed frame lengths
  always_ff @(posedge CLK) begin
    if (lq_we) lq_mem[lq_wr_q[LW-1:0]] <= tx_len_q;
  end

  assign mtx_clk = mtx_clk_q;
  assign mrx_clk = mtx_clk_q;
  assign mrxd = mrxd_q;
  assign mrxdv = mrxdv_q;
  assign mrxerr = mrxerr_q;
  assign mcoll = 1'b0;
  assign mcrs = (t_state_q == T_CAP) | mrxdv_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_mii_loopback_phy.sv
// tb_mii_loopback_phy: randomized loopback check against a frame-level timeline model
module tb_mii_loopback_phy;
  localparam int HALF = 2, DEPTH = 16, LQ = 4, TURN = 16, IFG = 24;
  localparam int MAXT = 2200, MAXF = 200;
  logic CLK = 1'b0, RST = 1'b1, loop_en = 1'b0, mtxen = 1'b0, mtxerr = 1'b0;
  logic [3:0] mtxd = 4'd0;
  logic mtx_clk, mrx_clk, mrxdv, mrxerr, mcoll, mcrs;
  logic [3:0] mrxd;
  logic [15:0] frame_cnt, drop_cnt;

  mii_loopback_phy #(.HALF(HALF), .DEPTH(DEPTH), .LQ_DEPTH(LQ), .TURN(TURN), .IFG(IFG)) dut (
    .CLK(CLK), .RST(RST), .loop_en(loop_en), .mtx_clk(mtx_clk), .mtxd(mtxd), .mtxen(mtxen),
    .mtxerr(mtxerr), .mrx_clk(mrx_clk), .mrxd(mrxd), .mrxdv(mrxdv), .mrxerr(mrxerr),
    .mcoll(mcoll), .mcrs(mcrs), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0, fails = 0, nt = 0, nf = 0;
  logic in_en[MAXT], in_er[MAXT], in_lp[MAXT];
  logic [3:0] in_d[MAXT];
  logic x_dv[MAXT], x_er[MAXT], x_crs[MAXT];
  logic [3:0] x_d[MAXT];
  logic [15:0] x_fc[MAXT], x_dc[MAXT];
  int fcd[MAXT], dcd[MAXT];
  int fr_s[MAXF], fr_l[MAXF];
  logic fr_lp[MAXF];
  int a_s[MAXF], a_l[MAXF], a_c[MAXF], a_p[MAXF];
  int lit_n[$], lit_k[$], lit_v[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_tl();
    for (int t = 0; t < MAXT; t++) begin
      in_en[t] = 0; in_er[t] = 0; in_d[t] = 0; in_lp[t] = 1'($urandom);
      x_dv[t] = 0; x_er[t] = 0; x_crs[t] = 0; x_d[t] = 0; x_fc[t] = 0; x_dc[t] = 0;
      fcd[t] = 0; dcd[t] = 0;
    end
    nf = 0;
    lit_n.delete(); lit_k.delete(); lit_v.delete();
  endtask

  task automatic add_frame(input int s, input int l, input logic lp);
    fr_s[nf] = s; fr_l[nf] = l; fr_lp[nf] = lp; nf++;
    for (int k = 0; k < l; k++) begin
      in_en[s+k] = 1; in_d[s+k] = 4'($urandom); in_er[s+k] = ($urandom_range(0, 7) == 0);
      in_lp[s+k] = lp;
    end
  endtask

  task automatic lit(input int n, input int k, input int v);
    lit_n.push_back(n); lit_k.push_back(k); lit_v.push_back(v);
  endtask

  // Frame-level model: decides accept/drop from queue/FIFO occupancy and schedules replay ticks
  task automatic build_model();
    int na, wc, idle, q, r, p, st, en, c, s, l;
    logic drop;
    na = 0; wc = 0; idle = 0;
    for (int i = 0; i < nf; i++) begin
      s = fr_s[i]; l = fr_l[i]; c = s + l;
      if (!fr_lp[i]) continue;
      for (int t = s; t < c && t < nt; t++) x_crs[t] = 1;
      q = 0;
      for (int j = 0; j < na; j++) if (a_c[j] < s && s <= a_p[j]) q++;
      drop = q >= LQ;
      for (int k = 0; k < l && !drop; k++) begin
        r = 0;
        for (int j = 0; j < na; j++) begin
          int d;
          d = s + k - a_s[j];
          r += d < 0 ? 0 : (d > a_l[j] ? a_l[j] : d);
        end
        if (wc + k - r >= DEPTH) drop = 1;
      end
      if (drop) begin
        if (c < nt) dcd[c]++;
      end else begin
        p = c > idle ? c : idle;
        st = p + TURN + 1;
        en = st + l;
        idle = en + IFG;
        a_s[na] = st; a_l[na] = l; a_c[na] = c; a_p[na] = p; na++;
        wc += l;
        for (int k = 0; k < l; k++) if (st + k < nt) begin
          x_dv[st+k] = 1; x_d[st+k] = in_d[s+k]; x_er[st+k] = in_er[s+k];
        end
        if (en < nt) fcd[en]++;
      end
    end
    for (int t = 1; t < nt; t++) begin
      x_fc[t] = x_fc[t-1] + 16'(fcd[t]);
      x_dc[t] = x_dc[t-1] + 16'(dcd[t]);
    end
    for (int t = 0; t < nt; t++) x_crs[t] = x_crs[t] | x_dv[t];
  endtask

  task automatic run_ticks(input int upto);
    int n;
    for (int e = 1; e <= 4 * upto; e++) begin
      @(posedge CLK);
      if (e % 4 == 2) begin
        #1;
        n = (e + 2) / 4;
        mtxen = n < nt ? in_en[n] : 1'b0;
        mtxd = n < nt ? in_d[n] : 4'd0;
        mtxerr = n < nt ? in_er[n] : 1'b0;
        loop_en = n < nt ? in_lp[n] : 1'b0;
      end
    end
    mtxen = 0; mtxd = 0; mtxerr = 0;
  endtask

  // Single compare process: reset values while RST is high, model timeline otherwise
  initial begin
    int e, n, k;
    logic [15:0] act;
    e = 0;
    forever begin
      @(posedge CLK or posedge RST);
      #1;
      if (RST) begin
        e = 0;
        chk("rst_mtx_clk", 16'(mtx_clk), 16'd0);
        chk("rst_mrx_clk", 16'(mrx_clk), 16'd0);
        chk("rst_mrxdv", 16'(mrxdv), 16'd0);
        chk("rst_mrxd", 16'(mrxd), 16'd0);
        chk("rst_mrxerr", 16'(mrxerr), 16'd0);
        chk("rst_mcrs", 16'(mcrs), 16'd0);
        chk("rst_mcoll", 16'(mcoll), 16'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
      end else begin
        e++;
        n = e / 4;
        if (n >= nt) n = nt - 1;
        chk("mtx_clk", 16'(mtx_clk), 16'((e / 2) % 2));
        chk("mrx_clk", 16'(mrx_clk), 16'((e / 2) % 2));
        chk("mcoll", 16'(mcoll), 16'd0);
        chk("mrxdv", 16'(mrxdv), 16'(x_dv[n]));
        chk("mrxd", 16'(mrxd), 16'(x_d[n]));
        chk("mrxerr", 16'(mrxerr), 16'(x_er[n]));
        chk("mcrs", 16'(mcrs), 16'(x_crs[n]));
        chk("frame_cnt", frame_cnt, x_fc[n]);
        chk("drop_cnt", drop_cnt, x_dc[n]);
        for (int i = 0; i < lit_n.size(); i++) if (lit_n[i] == n && e == 4 * n) begin
          k = lit_k[i];
          act = k == 0 ? 16'(mrxdv) : k == 1 ? 16'(mrxd) : k == 2 ? 16'(mrxerr) : k == 3 ? frame_cnt : drop_cnt;
          chk($sformatf("lit_t%0d_k%0d", n, k), act, 16'(lit_v[i]));
        end
      end
    end
  end

  initial begin
    int t, l;
    // Directed frames followed by random traffic
    clear_tl();
    add_frame(5, 8, 1);
    for (int k = 0; k < 8; k++) begin in_d[5+k] = k == 7 ? 4'hD : 4'h5; in_er[5+k] = 0; end
    add_frame(100, 8, 1);
    for (int k = 0; k < 8; k++) begin in_d[100+k] = k == 7 ? 4'hD : 4'h5; in_er[100+k] = k == 3; end
    add_frame(200, 20, 1);
    add_frame(222, 4, 1);
    for (int k = 0; k < 4; k++) begin in_d[222+k] = 4'(10 + k); in_er[222+k] = 0; end
    add_frame(300, 6, 1);
    add_frame(307, 6, 1);
    add_frame(450, 6, 0);
    t = 520;
    while (t < 1700 && nf < MAXF - 1) begin
      l = $urandom_range(1, 18);
      add_frame(t, l, $urandom_range(0, 9) != 0);
      t += l + (($urandom_range(0, 3) == 0) ? $urandom_range(20, 120) : $urandom_range(1, 4));
    end
    lit(29, 0, 0); lit(30, 0, 1); lit(30, 1, 5); lit(37, 1, 13); lit(38, 0, 0); lit(38, 3, 1);
    lit(127, 2, 0); lit(128, 2, 1); lit(128, 1, 5); lit(219, 4, 0); lit(220, 4, 1);
    lit(243, 1, 10); lit(246, 1, 13); lit(247, 3, 3); lit(369, 0, 0); lit(370, 0, 1);
    lit(376, 3, 5); lit(500, 3, 5); lit(500, 4, 1);
    nt = 2150;
    build_model();
    repeat (3) @(negedge CLK);
    RST = 0;
    run_ticks(nt);
    // Reset while replaying a frame and capturing another
    @(negedge CLK);
    RST = 1;
    clear_tl();
    add_frame(5, 8, 1);
    for (int k = 0; k < 8; k++) begin in_d[5+k] = k == 7 ? 4'hD : 4'h5; in_er[5+k] = 0; end
    add_frame(28, 10, 1);
    lit(30, 0, 1); lit(32, 0, 1); lit(32, 1, 5);
    nt = 200;
    build_model();
    repeat (2) @(negedge CLK);
    RST = 0;
    run_ticks(32);
    #3 RST = 1;
    // Nothing may replay after the reset
    clear_tl();
    nt = 150;
    build_model();
    repeat (2) @(negedge CLK);
    RST = 0;
    run_ticks(nt);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mii_loopback_phy.md
# mii_loopback_phy

Simulation-side MII PHY model that sits directly downstream of the Ethernet MAC's `macIO_*` pads in `SimTop`, replacing the unused external PHY. It generates the MII transmit and receive clocks, captures each frame the MAC transmits into a nibble FIFO, and replays it on the MII receive side after a fixed turnaround. This closes the MAC TX→RX loop for self-checking firmware tests. Frames that exceed buffering are dropped whole and counted.

## Interface
Parameters:
- `HALF`, 2: CLK cycles per MII clock half-period, ≥1.
- `DEPTH`, 4096: nibble FIFO entries, power of two.
- `LQ_DEPTH`, 4: frame-length queue entries, power of two.
- `TURN`, 16: nibble periods from capture commit to replay start.
- `IFG`, 24: idle nibble periods after each replayed frame.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: asynchronous, active-high reset.
- `loop_en` in 1: enables capture; sampled only at frame start.
- `mtx_clk` out 1: MII TX clock to MAC `macIO_mtx_clk_pad_i`.
- `mtxd` in 4, `mtxen` in 1, `mtxerr` in 1: MAC transmit nibble, enable, error.
- `mrx_clk` out 1: MII RX clock, identical to `mtx_clk`.
- `mrxd` out 4, `mrxdv` out 1, `mrxerr` out 1: replayed nibble, data valid, error.
- `mcoll` out 1: constant 0 (full duplex).
- `mcrs` out 1: carrier sense, `tx_active | mrxdv`.
- `frame_cnt` out 16: frames fully replayed, wraps.
- `drop_cnt` out 16: frames dropped, wraps.

## Operation
- Clock divider:
  - `div_cnt` counts 0..HALF-1. At HALF-1 it clears and `mtx_clk` toggles.
  - A rise tick is the CLK edge where `mtx_clk` goes 0→1. A fall tick is the edge where it goes 1→0.
  - All MII sampling and driving happens on fall ticks. The MAC therefore sees stable `mrx*` at the next rise.
- TX capture FSM, states T_IDLE and T_CAP:
  - T_IDLE → T_CAP on a fall tick with `mtxen`=1 and `loop_en`=1. That nibble is written. `tx_active` is set.
  - On that same fall tick, if the length queue is full, the frame is marked dropped and nothing is written.
  - In T_CAP, each fall tick with `mtxen`=1 writes {mtxerr, mtxd} (5 bits) to the FIFO and increments the frame length.
  - FIFO full on a write: set the drop flag, rewind the write pointer to the frame-start pointer, and stop writing for the rest of the frame.
  - Fall tick with `mtxen`=0 → T_IDLE and `tx_active` cleared.
    - If the frame is not dropped, push its length (clog2(DEPTH)+1 bits) to the length queue.
    - If dropped, increment `drop_cnt`.
  - `mtxen`=1 with `loop_en`=0 at frame start: the frame is ignored entirely and no counters change.
- RX replay FSM, states R_IDLE, R_WAIT, R_SEND, R_IFG:
  - R_IDLE → R_WAIT when the length queue is non-empty. Pop the length; load the wait counter with TURN.
  - R_WAIT: decrement on each fall tick. At 0 → R_SEND.
  - R_SEND: on each fall tick, pop one FIFO entry and drive `mrxd`/`mrxerr`/`mrxdv`=1.
    - After LEN nibbles, the next fall tick drives `mrxdv`=0, `mrxd`=0, `mrxerr`=0.
    - Increment `frame_cnt` and go → R_IFG, loaded with IFG.
  - R_IFG: count down on fall ticks, then → R_IDLE.
- Capture and replay run concurrently. The FIFO read/write pointers are clog2(DEPTH)+1 bits and wrap naturally. Full is MSBs differ with the rest equal; empty is the pointers equal.
- The replay pointer never overtakes committed data, because it reads only frames whose length has been queued.

## Timing
- Reset values: `mtx_clk`=`mrx_clk`=0, `mrxd`=0, `mrxdv`=0, `mrxerr`=0, `mcoll`=0, `mcrs`=0, `frame_cnt`=0, `drop_cnt`=0. FSMs are in T_IDLE/R_IDLE, FIFO and queue are empty, `div_cnt`=0.
- The first `mtx_clk` rise occurs HALF CLK cycles after `RST` deasserts. The MII period is 2·HALF CLK cycles.
- Latency: the first replayed nibble appears on the (TURN+1)th fall tick after the fall tick that saw `mtxen`=0.
- Replayed nibble order, values and error bits are identical to capture. `mrxdv` stays high for exactly LEN consecutive nibble periods.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), and partial frames are discarded.
- A commit push and a replay pop on the same CLK edge are both honoured.

## Test plan
- Reset release with HALF=2 → all outputs 0; `mtx_clk` toggles every 2 CLK (period 4); counters remain 0.
- 8-nibble frame 5,5,5,5,5,5,5,D with `loop_en`=1 → after 16 idle fall ticks, `mrxdv`=1 for exactly 8 nibble periods carrying 5,5,5,5,5,5,5,D; `frame_cnt`=1.
- Same frame with `mtxerr`=1 on nibble index 3 only → `mrxerr`=1 only on replayed nibble 3.
- DEPTH=16: a 20-nibble frame, then a 4-nibble frame A,B,C,D → first frame never replayed and `drop_cnt`=1; second frame replays A,B,C,D; `frame_cnt`=1.
- Two 6-nibble frames separated by 1 idle nibble → both replayed in order, `mrxdv` low for ≥24 nibble periods between them, `frame_cnt`=2; `loop_en`=0 on a third frame → no replay, counters unchanged.
- `RST` pulsed during R_SEND → `mrxdv` drops the same cycle; after release, no residual nibbles are replayed.
